// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command host: opcodes, command and state
// encodings, and per-command frame/response length lookups.
package uart_cmd_pkg;

    localparam logic [7:0] OP_RF_WR   = 8'hAA;
    localparam logic [7:0] OP_RF_RD   = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    // Index of the final byte of the request frame.
    function automatic logic [1:0] frame_last_idx(input cmd_type_e t);
        logic [1:0] r;
        case (t)
            CMD_RF_WR:   r = 2'd2;
            CMD_RF_RD:   r = 2'd1;
            CMD_ALU_OP:  r = 2'd3;
            CMD_ALU_NOP: r = 2'd1;
            default:     r = 2'd1;
        endcase
        return r;
    endfunction

    // Number of response bytes expected after the frame.
    function automatic logic [1:0] rsp_len(input cmd_type_e t);
        logic [1:0] r;
        case (t)
            CMD_RF_WR:   r = 2'd0;
            CMD_RF_RD:   r = 2'd1;
            CMD_ALU_OP:  r = 2'd2;
            CMD_ALU_NOP: r = 2'd2;
            default:     r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_host_rsp_timer.sv
// Response inactivity timer: synchronous clear, count enable, and a
// terminal-count flag at TMO_CYC-1.
module rsp_timer #(
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] cnt_q;

    // Clear has priority over enable so a byte arriving restarts the window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side UART command initiator: serializes one command into a byte frame,
// then gathers the response bytes or reports a timeout.
module uart_cmd_host
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4,
    parameter int TMO_W      = 16,
    parameter int TMO_CYC    = 1000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VLD,
    output logic                  CMD_RDY,
    input  logic [1:0]            CMD_TYPE,
    input  logic [RF_ADDR-1:0]    CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_A,
    input  logic [DATA_WIDTH-1:0] CMD_B,
    input  logic [3:0]            CMD_FUN,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VLD,
    input  logic                  TX_RDY,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_VLD,
    output logic                  RSP_VLD,
    output logic [15:0]           RSP_DATA,
    output logic                  RSP_TMO,
    output logic                  BUSY
);

    state_e                state_q;
    cmd_type_e             type_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] fun_q;
    logic [1:0]            idx_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_vld_q;
    logic                  rx_cnt_q;
    logic [7:0]            rx_buf_q;
    logic                  rsp_vld_q;
    logic [15:0]           rsp_data_q;
    logic                  rsp_tmo_q;

    logic                  tmo_tc_s;
    logic                  tmr_clr_s;
    logic                  tmr_en_s;
    logic [7:0]            rx_byte_s;
    logic [15:0]           rsp_merge_s;
    logic                  rx_last_s;
    logic                  tx_last_s;

    function automatic logic [DATA_WIDTH-1:0] frame_byte(
        input cmd_type_e             t,
        input logic [1:0]            idx,
        input logic [DATA_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [DATA_WIDTH-1:0] fun
    );
        logic [DATA_WIDTH-1:0] r;
        case (t)
            CMD_RF_WR: begin
                case (idx)
                    2'd0:    r = DATA_WIDTH'(OP_RF_WR);
                    2'd1:    r = addr;
                    default: r = a;
                endcase
            end
            CMD_RF_RD:   r = (idx == 2'd0) ? DATA_WIDTH'(OP_RF_RD) : addr;
            CMD_ALU_OP: begin
                case (idx)
                    2'd0:    r = DATA_WIDTH'(OP_ALU_OP);
                    2'd1:    r = a;
                    2'd2:    r = b;
                    default: r = fun;
                endcase
            end
            CMD_ALU_NOP: r = (idx == 2'd0) ? DATA_WIDTH'(OP_ALU_NOP) : fun;
            default:     r = '0;
        endcase
        return r;
    endfunction

    assign tmr_clr_s = (state_q != ST_WAIT_RSP) || RX_VLD;
    assign tmr_en_s  = (state_q == ST_WAIT_RSP) && !rsp_vld_q;

    rsp_timer #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_rsp_timer (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (tmr_clr_s),
        .en_i   (tmr_en_s),
        .tc_o   (tmo_tc_s)
    );

    // Response assembly: byte 0 lands low, byte 1 high; single-byte reads are zero-extended.
    always_comb begin
        rx_byte_s = RX_DATA[7:0];
        if (rx_cnt_q) begin
            rsp_merge_s = {rx_byte_s, rx_buf_q};
        end else begin
            rsp_merge_s = {8'h00, rx_byte_s};
        end
        rx_last_s = ({1'b0, rx_cnt_q} == (rsp_len(type_q) - 2'd1));
        tx_last_s = (idx_q == frame_last_idx(type_q));
    end

    // Command FSM. The completion pulse is issued while still busy; IDLE follows a cycle later.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            type_q     <= CMD_RF_WR;
            addr_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            idx_q      <= 2'd0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            rx_cnt_q   <= 1'b0;
            rx_buf_q   <= 8'h00;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= 16'h0000;
            rsp_tmo_q  <= 1'b0;
        end else begin
            rsp_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (CMD_VLD) begin
                        type_q    <= cmd_type_e'(CMD_TYPE);
                        addr_q    <= DATA_WIDTH'(CMD_ADDR);
                        a_q       <= CMD_A;
                        b_q       <= CMD_B;
                        fun_q     <= DATA_WIDTH'(CMD_FUN);
                        idx_q     <= 2'd0;
                        tx_data_q <= frame_byte(cmd_type_e'(CMD_TYPE), 2'd0, DATA_WIDTH'(CMD_ADDR),
                                                CMD_A, CMD_B, DATA_WIDTH'(CMD_FUN));
                        tx_vld_q  <= 1'b1;
                        rx_cnt_q  <= 1'b0;
                        rx_buf_q  <= 8'h00;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (rsp_vld_q) begin
                        state_q <= ST_IDLE;
                    end else if (tx_vld_q && TX_RDY) begin
                        if (tx_last_s) begin
                            tx_vld_q <= 1'b0;
                            if (rsp_len(type_q) == 2'd0) begin
                                rsp_vld_q  <= 1'b1;
                                rsp_data_q <= 16'h0000;
                                rsp_tmo_q  <= 1'b0;
                            end else begin
                                state_q <= ST_WAIT_RSP;
                            end
                        end else begin
                            idx_q     <= idx_q + 2'd1;
                            tx_data_q <= frame_byte(type_q, idx_q + 2'd1, addr_q, a_q, b_q, fun_q);
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_vld_q) begin
                        state_q <= ST_IDLE;
                    end else if (RX_VLD) begin
                        if (rx_last_s) begin
                            rsp_vld_q  <= 1'b1;
                            rsp_data_q <= rsp_merge_s;
                            rsp_tmo_q  <= 1'b0;
                        end else begin
                            rx_buf_q <= rx_byte_s;
                            rx_cnt_q <= 1'b1;
                        end
                    end else if (tmo_tc_s) begin
                        rsp_vld_q  <= 1'b1;
                        rsp_data_q <= {8'h00, rx_buf_q};
                        rsp_tmo_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    tx_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign CMD_RDY  = (state_q == ST_IDLE);
    assign BUSY     = (state_q != ST_IDLE);
    assign TX_DATA  = tx_data_q;
    assign TX_VLD   = tx_vld_q;
    assign RSP_VLD  = rsp_vld_q;
    assign RSP_DATA = rsp_data_q;
    assign RSP_TMO  = rsp_tmo_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed self-checking bench for uart_cmd_host: frames, stalls, responses,
// timeout, dropped RX bytes and asynchronous reset.
module tb_uart_cmd_host;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_VLD = 1'b0;
    logic        CMD_RDY;
    logic [1:0]  CMD_TYPE = 2'd0;
    logic [3:0]  CMD_ADDR = 4'd0;
    logic [7:0]  CMD_A = 8'h00;
    logic [7:0]  CMD_B = 8'h00;
    logic [3:0]  CMD_FUN = 4'd0;
    logic [7:0]  TX_DATA;
    logic        TX_VLD;
    logic        TX_RDY = 1'b1;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VLD = 1'b0;
    logic        RSP_VLD;
    logic [15:0] RSP_DATA;
    logic        RSP_TMO;
    logic        BUSY;

    int checks = 0;
    int failures = 0;

    uart_cmd_host dut (
        .CLK      (CLK),
        .RST      (RST),
        .CMD_VLD  (CMD_VLD),
        .CMD_RDY  (CMD_RDY),
        .CMD_TYPE (CMD_TYPE),
        .CMD_ADDR (CMD_ADDR),
        .CMD_A    (CMD_A),
        .CMD_B    (CMD_B),
        .CMD_FUN  (CMD_FUN),
        .TX_DATA  (TX_DATA),
        .TX_VLD   (TX_VLD),
        .TX_RDY   (TX_RDY),
        .RX_DATA  (RX_DATA),
        .RX_VLD   (RX_VLD),
        .RSP_VLD  (RSP_VLD),
        .RSP_DATA (RSP_DATA),
        .RSP_TMO  (RSP_TMO),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic issue(input string name, input logic [1:0] t, input logic [3:0] ad,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        chk({name, "_cmd_rdy"}, {31'd0, CMD_RDY}, 32'd1);
        CMD_VLD = 1'b1; CMD_TYPE = t; CMD_ADDR = ad; CMD_A = a; CMD_B = b; CMD_FUN = f;
        tick();
        CMD_VLD = 1'b0;
        chk({name, "_busy"}, {31'd0, BUSY}, 32'd1);
        chk({name, "_tx_vld_rise"}, {31'd0, TX_VLD}, 32'd1);
    endtask

    // Bytes expected: byte k at exp[8k +: 8]. toggle stalls TX_RDY on even cycles.
    task automatic collect(input string name, input int n, input logic [31:0] exp,
                           input bit toggle, input bit consec);
        int k = 0;
        int cyc = 0;
        bit hold_v = 1'b0;
        logic [7:0] held = 8'h00;
        while (k < n && cyc < 40) begin
            TX_RDY = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (hold_v && TX_VLD) chk($sformatf("%s_stable%0d", name, k), {24'd0, TX_DATA}, {24'd0, held});
            hold_v = 1'b0;
            if (TX_VLD && TX_RDY) begin
                chk($sformatf("%s_byte%0d", name, k), {24'd0, TX_DATA}, {24'd0, exp[8*k +: 8]});
                k++;
            end else if (TX_VLD) begin
                hold_v = 1'b1;
                held = TX_DATA;
            end
            tick();
            cyc++;
        end
        TX_RDY = 1'b1;
        chk({name, "_nbytes"}, k, n);
        if (consec) chk({name, "_cycles"}, cyc, n);
        chk({name, "_tx_drop"}, {31'd0, TX_VLD}, 32'd0);
    endtask

    task automatic rx(input logic [7:0] d);
        RX_VLD = 1'b1; RX_DATA = d;
        tick();
        RX_VLD = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic [15:0] d, input logic tmo);
        chk({name, "_rsp_vld"}, {31'd0, RSP_VLD}, 32'd1);
        chk({name, "_rsp_data"}, {16'd0, RSP_DATA}, {16'd0, d});
        chk({name, "_rsp_tmo"}, {31'd0, RSP_TMO}, {31'd0, tmo});
        chk({name, "_rdy_in_pulse"}, {31'd0, CMD_RDY}, 32'd0);
        tick();
        chk({name, "_rsp_pulse_end"}, {31'd0, RSP_VLD}, 32'd0);
        chk({name, "_rdy_after"}, {31'd0, CMD_RDY}, 32'd1);
        chk({name, "_rsp_hold"}, {16'd0, RSP_DATA}, {16'd0, d});
    endtask

    initial begin
        int n;
        // Reset state
        @(negedge CLK);
        chk("rst_cmd_rdy", {31'd0, CMD_RDY}, 32'd1);
        chk("rst_tx_vld", {31'd0, TX_VLD}, 32'd0);
        chk("rst_tx_data", {24'd0, TX_DATA}, 32'd0);
        chk("rst_rsp_vld", {31'd0, RSP_VLD}, 32'd0);
        chk("rst_rsp_data", {16'd0, RSP_DATA}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        tick();
        RST = 1'b1;
        tick();

        // RF_WR, addr 3, data 20, back-to-back transfers
        issue("wr", 2'd0, 4'd3, 8'h20, 8'h00, 4'd0);
        collect("wr", 3, {8'h00, 8'h20, 8'h03, 8'hAA}, 1'b0, 1'b1);
        expect_rsp("wr", 16'h0000, 1'b0);

        // RF_RD, addr 1, stalled transmitter, response 5A
        issue("rd", 2'd1, 4'd1, 8'h00, 8'h00, 4'd0);
        collect("rd", 2, {16'h0000, 8'h01, 8'hBB}, 1'b1, 1'b0);
        chk("rd_wait_busy", {31'd0, BUSY}, 32'd1);
        tick();
        chk("rd_no_early_rsp", {31'd0, RSP_VLD}, 32'd0);
        rx(8'h5A);
        expect_rsp("rd", 16'h005A, 1'b0);

        // ALU_OP 7,9 fun 0, response bytes 10 then 00
        issue("alu", 2'd2, 4'd0, 8'h07, 8'h09, 4'd0);
        collect("alu", 4, {8'h00, 8'h09, 8'h07, 8'hCC}, 1'b0, 1'b1);
        rx(8'h10);
        chk("alu_mid_rsp", {31'd0, RSP_VLD}, 32'd0);
        rx(8'h00);
        expect_rsp("alu", 16'h0010, 1'b0);

        // ALU_NOP fun 1, only one response byte, then timeout
        issue("nop", 2'd3, 4'd0, 8'h00, 8'h00, 4'd1);
        collect("nop", 2, {16'h0000, 8'h01, 8'hDD}, 1'b0, 1'b1);
        rx(8'h34);
        n = 0;
        while (!RSP_VLD && n < 1100) begin
            tick();
            n++;
        end
        chk("nop_tmo_latency", n, 1000);
        expect_rsp("nop", 16'h0034, 1'b1);

        // RX bytes in IDLE and SEND are dropped
        tick();
        rx(8'hFF);
        chk("drop_idle_rsp", {31'd0, RSP_VLD}, 32'd0);
        issue("drop", 2'd1, 4'd2, 8'h00, 8'h00, 4'd0);
        TX_RDY = 1'b0;
        rx(8'hFF);
        chk("drop_send_rsp", {31'd0, RSP_VLD}, 32'd0);
        TX_RDY = 1'b1;
        collect("drop", 2, {16'h0000, 8'h02, 8'hBB}, 1'b0, 1'b1);
        tick();
        chk("drop_wait_rsp", {31'd0, RSP_VLD}, 32'd0);
        rx(8'h11);
        expect_rsp("drop", 16'h0011, 1'b0);

        // Asynchronous reset with ALU_OP byte 2 pending
        issue("arst", 2'd2, 4'd0, 8'h44, 8'h55, 4'd2);
        tick();
        TX_RDY = 1'b0;
        chk("arst_pending_vld", {31'd0, TX_VLD}, 32'd1);
        chk("arst_pending_data", {24'd0, TX_DATA}, 32'h44);
        #2 RST = 1'b0;
        #1;
        chk("arst_tx_vld", {31'd0, TX_VLD}, 32'd0);
        chk("arst_busy", {31'd0, BUSY}, 32'd0);
        chk("arst_cmd_rdy", {31'd0, CMD_RDY}, 32'd1);
        chk("arst_rsp_vld", {31'd0, RSP_VLD}, 32'd0);
        chk("arst_rsp_data", {16'd0, RSP_DATA}, 32'd0);
        @(negedge CLK);
        tick();
        RST = 1'b1;
        TX_RDY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("arst_no_rsp%0d", i), {31'd0, RSP_VLD}, 32'd0);
            chk($sformatf("arst_idle%0d", i), {31'd0, TX_VLD}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
